layer_cfg_bank: RTL and testbench
=================================

Name: layer_cfg_bank

Overview:
Multi-channel, double-buffered timing-configuration bank for the NeoPixel output layers.
- Host byte writes land in per-channel shadow registers.
- A commit request copies shadow to active only when the target channel reports it is idle between frames, so a waveform never changes mid-frame.
- Sits between the host register interface and CH_NUM waveform generators; also provides per-channel pending/done status and optional register readback.

Parameters:
CH_NUM, 8, number of output channels (1..8); channel index is wr_addr_in[5:3]
CNT_WIDTH, 8, width of each t0h/t0l/t1h/t1l count (1..8); low bits of wr_data_in are used
RST_WIDTH, 16, width of reset count (9..16); built from hi byte (reg 4) and lo byte (reg 5), truncated to RST_WIDTH

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
wr_en_in  input  1  write strobe, one byte per cycle
wr_addr_in  input  6  [5:3] channel, [2:0] register index
wr_data_in  input  8  write data
rd_en_in  input  1  read strobe
rd_addr_in  input  6  read address, same map as writes
rd_data_out  output  8  read data, valid 1 cycle after rd_en_in
ch_idle_in  input  CH_NUM  per-channel "between frames" flag from the waveform generators
t0h_cnt_out  output  CH_NUM*CNT_WIDTH  active T0H counts, channel n at [n*CNT_WIDTH +: CNT_WIDTH]
t0l_cnt_out  output  CH_NUM*CNT_WIDTH  active T0L counts
t1h_cnt_out  output  CH_NUM*CNT_WIDTH  active T1H counts
t1l_cnt_out  output  CH_NUM*CNT_WIDTH  active T1L counts
rst_cnt_out  output  CH_NUM*RST_WIDTH  active reset counts
pend_out  output  CH_NUM  commit pending, per channel
upd_done_out  output  CH_NUM  1-cycle pulse when the active set is updated

Behaviour:
Register map (index):
- 0 t0h, 1 t0l, 2 t1h, 3 t1l
- 4 rst[15:8], 5 rst[7:0]
- 6 control, write-only: bit0 commit this channel; bit1 commit all channels
- 7 reserved; writes ignored, reads 0

Writes:
- Writes to indices 0-5 update the shadow register on the next clock edge.
- Writes with channel index >= CH_NUM are ignored. The exception is a control write with bit1 set, which is honoured from any channel index.

Commit handshake:
- A control commit sets pend[n].
- While pend[n]=1 and ch_idle_in[n]=1 on a clock edge, all shadow[n] fields copy to active[n], pend[n] clears, and upd_done_out[n] pulses high for exactly that following cycle.
- If ch_idle_in[n]=1 when the commit is written, the transfer occurs on the next edge. Minimum latency from control write to active update is 2 cycles.
- pend stays set indefinitely while the channel is busy.

Simultaneous events:
- Shadow write in the same cycle as a transfer: active takes the old shadow value; shadow takes the new value.
- Commit written in the same cycle as a transfer on that channel: transfer proceeds and pend[n] remains 1, so a second transfer follows.
- Repeated commits while pending: no extra effect.

Reset (async, any time including mid-commit):
- All shadow, active, pend, upd_done_out and rd_data_out go to 0 immediately.

Readback:
- rd_en_in at cycle t gives rd_data_out at t+1.
- Indices 0-5 return the active value, zero-extended; rst hi/lo return the corresponding bytes.
- Index 6 returns {6'b0, ch_idle_in[n], pend[n]}.
- Out-of-range channel returns 0.
- rd_data_out holds its value when rd_en_in=0.

Optional Feature:
LAYER_CFG_BANK_SHADOW_RDBK_EN
- Defined: rd_addr_in[2:0] indices 0-5 return shadow values instead of active values, so the host can verify staged data before committing. Index 6 is unchanged.
- Undefined: readback returns active values as described above.

Test Plan:
1. Reset, write ch0 idx0=0x20, no commit, ch_idle_in=all 1 -> t0h_cnt_out[7:0] stays 0x00, pend_out=0.
2. Write ch2 idx0..5 = 0x10,0x30,0x28,0x18,0x12,0x34, ch_idle_in[2]=0, commit ch2 -> pend_out[2]=1, outputs unchanged for 50 cycles. Raise idle -> next edge: ch2 counts 0x10/0x30/0x28/0x18, rst 0x1234; upd_done_out[2] one-cycle pulse; pend_out[2]=0.
3. Broadcast commit (idx6=0x02) written via channel 7 with CH_NUM=4, ch_idle_in=4'b0101 -> ch0 and ch2 update next edge; ch1 and ch3 stay pending until their idle bits rise.
4. Same-cycle commit and transfer on ch1 -> two upd_done_out[1] pulses, the second carrying the newer shadow values.
5. Assert rst_n_in low while pend_out=4'hF -> all outputs 0 asynchronously; after release there are no spurious updates.
6. Read ch2 idx4 after test 2 -> rd_data_out=0x12 one cycle after rd_en_in. Read idx6 -> 0x02 (idle=1, pend=0). With LAYER_CFG_BANK_SHADOW_RDBK_EN, a staged uncommitted 0x55 reads 0x55.

Source files
------------

// File: rtl/layer_cfg_bank.sv
// rtl/layer_cfg_bank.sv - double-buffered per-channel NeoPixel timing configuration bank
// Optional LAYER_CFG_BANK_SHADOW_RDBK_EN: readback of indices 0-5 returns shadow instead of active values.
module layer_cfg_bank #(
  parameter int CH_NUM    = 8,
  parameter int CNT_WIDTH = 8,
  parameter int RST_WIDTH = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          wr_en_in,
  input  logic [5:0]                    wr_addr_in,
  input  logic [7:0]                    wr_data_in,
  input  logic                          rd_en_in,
  input  logic [5:0]                    rd_addr_in,
  output logic [7:0]                    rd_data_out,
  input  logic [CH_NUM-1:0]             ch_idle_in,
  output logic [CH_NUM*CNT_WIDTH-1:0]   t0h_cnt_out,
  output logic [CH_NUM*CNT_WIDTH-1:0]   t0l_cnt_out,
  output logic [CH_NUM*CNT_WIDTH-1:0]   t1h_cnt_out,
  output logic [CH_NUM*CNT_WIDTH-1:0]   t1l_cnt_out,
  output logic [CH_NUM*RST_WIDTH-1:0]   rst_cnt_out,
  output logic [CH_NUM-1:0]             pend_out,
  output logic [CH_NUM-1:0]             upd_done_out
);

  logic [2:0]           w_wr_ch, w_wr_idx, w_rd_ch, w_rd_idx;
  logic [CH_NUM-1:0]    w_commit, w_xfer;
  logic [7:0]           w_rd_val;

  logic [CNT_WIDTH-1:0] r_sh_t0h [CH_NUM];
  logic [CNT_WIDTH-1:0] r_sh_t0l [CH_NUM];
  logic [CNT_WIDTH-1:0] r_sh_t1h [CH_NUM];
  logic [CNT_WIDTH-1:0] r_sh_t1l [CH_NUM];
  logic [RST_WIDTH-1:0] r_sh_rst [CH_NUM];
  logic [CNT_WIDTH-1:0] r_act_t0h [CH_NUM];
  logic [CNT_WIDTH-1:0] r_act_t0l [CH_NUM];
  logic [CNT_WIDTH-1:0] r_act_t1h [CH_NUM];
  logic [CNT_WIDTH-1:0] r_act_t1l [CH_NUM];
  logic [RST_WIDTH-1:0] r_act_rst [CH_NUM];

  logic [CNT_WIDTH-1:0] w_src_t0h [CH_NUM];
  logic [CNT_WIDTH-1:0] w_src_t0l [CH_NUM];
  logic [CNT_WIDTH-1:0] w_src_t1h [CH_NUM];
  logic [CNT_WIDTH-1:0] w_src_t1l [CH_NUM];
  logic [15:0]          w_src_rst [CH_NUM];

  logic [CH_NUM-1:0]    r_pend, r_done;
  logic [7:0]           r_rd_data;

  assign w_wr_ch  = wr_addr_in[5:3];
  assign w_wr_idx = wr_addr_in[2:0];
  assign w_rd_ch  = rd_addr_in[5:3];
  assign w_rd_idx = rd_addr_in[2:0];
  assign w_xfer   = r_pend & ch_idle_in;

  // Channel match against a loop constant also filters out-of-range channel writes.
  always_comb begin
    w_commit = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      if (wr_en_in && (w_wr_idx == 3'd6) &&
          (wr_data_in[1] || (wr_data_in[0] && (w_wr_ch == 3'(n)))))
        w_commit[n] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int n = 0; n < CH_NUM; n++) begin
        r_sh_t0h[n]  <= '0;
        r_sh_t0l[n]  <= '0;
        r_sh_t1h[n]  <= '0;
        r_sh_t1l[n]  <= '0;
        r_sh_rst[n]  <= '0;
        r_act_t0h[n] <= '0;
        r_act_t0l[n] <= '0;
        r_act_t1h[n] <= '0;
        r_act_t1l[n] <= '0;
        r_act_rst[n] <= '0;
      end
      r_pend    <= '0;
      r_done    <= '0;
      r_rd_data <= '0;
    end else begin
      // A commit landing on a transfer edge re-arms pend for a second transfer.
      r_pend <= (r_pend & ~w_xfer) | w_commit;
      r_done <= w_xfer;
      if (rd_en_in)
        r_rd_data <= w_rd_val;
      for (int n = 0; n < CH_NUM; n++) begin
        if (w_xfer[n]) begin
          r_act_t0h[n] <= r_sh_t0h[n];
          r_act_t0l[n] <= r_sh_t0l[n];
          r_act_t1h[n] <= r_sh_t1h[n];
          r_act_t1l[n] <= r_sh_t1l[n];
          r_act_rst[n] <= r_sh_rst[n];
        end
        if (wr_en_in && (w_wr_ch == 3'(n))) begin
          case (w_wr_idx)
            3'd0:    r_sh_t0h[n] <= wr_data_in[CNT_WIDTH-1:0];
            3'd1:    r_sh_t0l[n] <= wr_data_in[CNT_WIDTH-1:0];
            3'd2:    r_sh_t1h[n] <= wr_data_in[CNT_WIDTH-1:0];
            3'd3:    r_sh_t1l[n] <= wr_data_in[CNT_WIDTH-1:0];
            3'd4:    r_sh_rst[n][RST_WIDTH-1:8] <= wr_data_in[RST_WIDTH-9:0];
            3'd5:    r_sh_rst[n][7:0] <= wr_data_in;
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
`ifdef LAYER_CFG_BANK_SHADOW_RDBK_EN
    assign w_src_t0h[g] = r_sh_t0h[g];
    assign w_src_t0l[g] = r_sh_t0l[g];
    assign w_src_t1h[g] = r_sh_t1h[g];
    assign w_src_t1l[g] = r_sh_t1l[g];
    assign w_src_rst[g] = 16'(r_sh_rst[g]);
`else
    assign w_src_t0h[g] = r_act_t0h[g];
    assign w_src_t0l[g] = r_act_t0l[g];
    assign w_src_t1h[g] = r_act_t1h[g];
    assign w_src_t1l[g] = r_act_t1l[g];
    assign w_src_rst[g] = 16'(r_act_rst[g]);
`endif
    assign t0h_cnt_out[g*CNT_WIDTH +: CNT_WIDTH] = r_act_t0h[g];
    assign t0l_cnt_out[g*CNT_WIDTH +: CNT_WIDTH] = r_act_t0l[g];
    assign t1h_cnt_out[g*CNT_WIDTH +: CNT_WIDTH] = r_act_t1h[g];
    assign t1l_cnt_out[g*CNT_WIDTH +: CNT_WIDTH] = r_act_t1l[g];
    assign rst_cnt_out[g*RST_WIDTH +: RST_WIDTH] = r_act_rst[g];
  end

  always_comb begin
    w_rd_val = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      if (w_rd_ch == 3'(n)) begin
        case (w_rd_idx)
          3'd0:    w_rd_val = 8'(w_src_t0h[n]);
          3'd1:    w_rd_val = 8'(w_src_t0l[n]);
          3'd2:    w_rd_val = 8'(w_src_t1h[n]);
          3'd3:    w_rd_val = 8'(w_src_t1l[n]);
          3'd4:    w_rd_val = w_src_rst[n][15:8];
          3'd5:    w_rd_val = w_src_rst[n][7:0];
          3'd6:    w_rd_val = {6'b0, ch_idle_in[n], r_pend[n]};
          default: w_rd_val = '0;
        endcase
      end
    end
  end

  assign rd_data_out  = r_rd_data;
  assign pend_out     = r_pend;
  assign upd_done_out = r_done;

endmodule

// File: tb/tb_layer_cfg_bank.sv
// tb/tb_layer_cfg_bank.sv - directed self-checking bench for layer_cfg_bank (CH_NUM=4)
module tb_layer_cfg_bank;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0;
  logic            rd_en = 1'b0;
  logic [5:0]      wr_addr = '0;
  logic [5:0]      rd_addr = '0;
  logic [7:0]      wr_data = '0;
  logic [7:0]      rd_data;
  logic [CH-1:0]   idle = '1;
  logic [CH*8-1:0] t0h, t0l, t1h, t1l;
  logic [CH*16-1:0] rstc;
  logic [CH-1:0]   pend, done;

  int         n_vec = 0;
  int         n_fail = 0;
  logic [7:0] sb_q[$];
  string      tag_q[$];
  logic [7:0] exp_ch2_t0h;

  layer_cfg_bank #(.CH_NUM(CH), .CNT_WIDTH(8), .RST_WIDTH(16)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_data_in(wr_data),
    .rd_en_in(rd_en), .rd_addr_in(rd_addr), .rd_data_out(rd_data),
    .ch_idle_in(idle),
    .t0h_cnt_out(t0h), .t0l_cnt_out(t0l), .t1h_cnt_out(t1h), .t1l_cnt_out(t1l),
    .rst_cnt_out(rstc), .pend_out(pend), .upd_done_out(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int ch, input int idx, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = {3'(ch), 3'(idx)}; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input int ch, input int idx, input logic [7:0] exp, input string tag);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = {3'(ch), 3'(idx)};
    sb_q.push_back(exp); tag_q.push_back(tag);
    @(negedge clk);
    rd_en = 1'b0;
    chk(tag_q.pop_front(), 64'(rd_data), 64'(sb_q.pop_front()));
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_t0h", 64'(t0h), 0);
    chk("rst_rstc", rstc, 0);
    chk("rst_pend", 64'(pend), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_rd", 64'(rd_data), 0);
    rst_n = 1'b1;

    // 1: write without commit leaves active untouched
    wr(0, 0, 8'h20);
    repeat (3) @(negedge clk);
    chk("t1_t0h_ch0", 64'(t0h[7:0]), 0);
    chk("t1_pend", 64'(pend), 0);

    // 2: commit on a busy channel waits for idle
    idle = 4'b1011;
    wr(2, 0, 8'h10); wr(2, 1, 8'h30); wr(2, 2, 8'h28);
    wr(2, 3, 8'h18); wr(2, 4, 8'h12); wr(2, 5, 8'h34);
    wr(2, 6, 8'h01);
    chk("t2_pend_set", 64'(pend), 64'h4);
    for (int i = 0; i < 5; i++) begin
      repeat (10) @(negedge clk);
      chk("t2_hold_t0h", 64'(t0h[16 +: 8]), 0);
      chk("t2_hold_done", 64'(done), 0);
    end
    idle = 4'b1111;
    @(negedge clk);
    chk("t2_t0h", 64'(t0h[16 +: 8]), 64'h10);
    chk("t2_t0l", 64'(t0l[16 +: 8]), 64'h30);
    chk("t2_t1h", 64'(t1h[16 +: 8]), 64'h28);
    chk("t2_t1l", 64'(t1l[16 +: 8]), 64'h18);
    chk("t2_rst", 64'(rstc[32 +: 16]), 64'h1234);
    chk("t2_done", 64'(done), 64'h4);
    chk("t2_pend_clr", 64'(pend), 0);
    @(negedge clk);
    chk("t2_done_pulse", 64'(done), 0);

    // 6: readback
    rd(2, 4, 8'h12, "t6_rd_rsthi");
    @(negedge clk);
    chk("t6_rd_hold", 64'(rd_data), 64'h12);
    rd(2, 5, 8'h34, "t6_rd_rstlo");
    rd(2, 0, 8'h10, "t6_rd_t0h");
    rd(2, 6, 8'h02, "t6_rd_ctrl");
    rd(2, 7, 8'h00, "t6_rd_resv");
    rd(5, 0, 8'h00, "t6_rd_oor");
    wr(2, 0, 8'h55);
`ifdef LAYER_CFG_BANK_SHADOW_RDBK_EN
    rd(2, 0, 8'h55, "t6_rd_staged");
`else
    rd(2, 0, 8'h10, "t6_rd_staged");
`endif
    exp_ch2_t0h = 8'h55;

    // 3: broadcast commit through an out-of-range channel index
    wr(1, 0, 8'h11); wr(3, 0, 8'h33);
    wr(6, 0, 8'h66);
    idle = 4'b0101;
    wr(7, 6, 8'h02);
    chk("t3_pend_all", 64'(pend), 64'hF);
    @(negedge clk);
    chk("t3_done02", 64'(done), 64'h5);
    chk("t3_pend13", 64'(pend), 64'hA);
    chk("t3_ch0", 64'(t0h[0 +: 8]), 64'h20);
    chk("t3_ch2", 64'(t0h[16 +: 8]), 64'(exp_ch2_t0h));
    chk("t3_ch1_old", 64'(t0h[8 +: 8]), 0);
    repeat (5) @(negedge clk);
    chk("t3_still_pend", 64'(pend), 64'hA);
    idle = 4'b0111;
    @(negedge clk);
    chk("t3_ch1", 64'(t0h[8 +: 8]), 64'h11);
    chk("t3_done1", 64'(done), 64'h2);
    idle = 4'b1111;
    @(negedge clk);
    chk("t3_ch3", 64'(t0h[24 +: 8]), 64'h33);
    chk("t3_done3", 64'(done), 64'h8);
    chk("t3_pend_clr", 64'(pend), 0);

    // 4: commit written on the transfer edge re-arms pend
    idle = 4'b1101;
    wr(1, 0, 8'hA1);
    wr(1, 6, 8'h01);
    wr(1, 6, 8'h01);
    chk("t4_pend", 64'(pend), 64'h2);
    @(negedge clk);
    idle = 4'b1111;
    wr_en = 1'b1; wr_addr = {3'd1, 3'd6}; wr_data = 8'h01;
    @(negedge clk);
    wr_en = 1'b0; idle = 4'b1101;
    chk("t4_done_a", 64'(done), 64'h2);
    chk("t4_t0h_a", 64'(t0h[8 +: 8]), 64'hA1);
    chk("t4_pend_kept", 64'(pend), 64'h2);
    wr(1, 0, 8'hB1);
    chk("t4_gap_done", 64'(done), 0);
    idle = 4'b1111;
    @(negedge clk);
    chk("t4_done_b", 64'(done), 64'h2);
    chk("t4_t0h_b", 64'(t0h[8 +: 8]), 64'hB1);
    chk("t4_pend_clr", 64'(pend), 0);

    // 5: async reset with every channel pending
    rd(2, 5, 8'h34, "t5_rd_pre");
    idle = 4'b0000;
    wr(0, 6, 8'h02);
    chk("t5_pend_all", 64'(pend), 64'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_t0h", 64'(t0h), 0);
    chk("t5_rstc", rstc, 0);
    chk("t5_pend", 64'(pend), 0);
    chk("t5_rd", 64'(rd_data), 0);
    @(negedge clk);
    rst_n = 1'b1; idle = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_done", 64'(done), 0);
      chk("t5_no_upd", 64'(t0h), 0);
    end
    rd(2, 0, 8'h00, "t5_rd_cleared");

    chk("sb_empty", 64'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
